// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: sequences one 1-D convolution row pass. It slides a
// K-tap filter across an L-entry IFMap row at stride S, drives scratchpad
// read addresses and MAC controls per tap, and writes each finished partial
// sum to the Psum buffer, stalling while the buffer reports full.
module conv_row_scheduler #(
    parameter int IFMAP_POINTER_SIZE   = 4,
    parameter int FILTER_POINTER_SIZE  = 4,
    parameter int FILTER_SIZE_REG_SIZE = 2,
    parameter int STRIDE_SIZE          = 3,
    parameter int PSUM_POINTER_SIZE    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            chip_en,
    input  logic                            start,
    input  logic [STRIDE_SIZE-1:0]          stride,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    input  logic [IFMAP_POINTER_SIZE:0]     row_len,
    input  logic                            psum_full,
    output logic [IFMAP_POINTER_SIZE-1:0]   ifmap_raddr,
    output logic [FILTER_POINTER_SIZE-1:0]  filter_raddr,
    output logic                            mac_en,
    output logic                            acc_clr,
    output logic                            psum_wen,
    output logic [PSUM_POINTER_SIZE-1:0]    psum_waddr,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide enough that base + stride + taps can never wrap.
    localparam int FIT_W = IFMAP_POINTER_SIZE + STRIDE_SIZE + 1;
    localparam int LEN_W = IFMAP_POINTER_SIZE + 1;

    state_t                          state_q, state_d;
    logic [IFMAP_POINTER_SIZE-1:0]   base_q, base_d;
    logic [FILTER_SIZE_REG_SIZE-1:0] tap_q, tap_d;
    logic [PSUM_POINTER_SIZE-1:0]    out_q, out_d;

    // Pass configuration captured when start is accepted.
    logic [FILTER_SIZE_REG_SIZE-1:0] k_q;
    logic [STRIDE_SIZE-1:0]          s_q;
    logic [LEN_W-1:0]                l_q;

    logic                            accept;
    logic                            no_work;
    logic [STRIDE_SIZE-1:0]          stride_eff;
    logic                            last_tap;
    logic [FIT_W-1:0]                fit_sum;
    logic                            window_fits;

    assign accept      = (state_q == IDLE) && start;
    // N is zero when there are no taps or the row is shorter than the filter.
    assign no_work     = (filter_size == '0) || (row_len < LEN_W'(filter_size));
    assign stride_eff  = (stride == '0) ? STRIDE_SIZE'(1) : stride;
    assign last_tap    = (tap_q == (k_q - FILTER_SIZE_REG_SIZE'(1)));
    // Next window [base+S, base+S+K-1] fits when base+S+K <= L.
    assign fit_sum     = FIT_W'(base_q) + FIT_W'(s_q) + FIT_W'(k_q);
    assign window_fits = (fit_sum <= FIT_W'(l_q));

    // State and counter registers; chip_en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            tap_q   <= '0;
            out_q   <= '0;
        end else if (chip_en) begin
            state_q <= state_d;
            base_q  <= base_d;
            tap_q   <= tap_d;
            out_q   <= out_d;
        end
    end

    // Configuration latch: inputs only matter on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            s_q <= '0;
            l_q <= '0;
        end else if (chip_en && accept) begin
            k_q <= filter_size;
            s_q <= stride_eff;
            l_q <= row_len;
        end
    end

    // Next-state and counter updates for the row walk.
    // Psum handshake: psum_wen is the valid, !psum_full the ready; a partial
    // sum is transferred (and out_idx advances) only in a WRITE cycle where
    // psum_full is low, otherwise WRITE holds with psum_wen low.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        tap_d   = tap_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = '0;
                    tap_d   = '0;
                    out_d   = '0;
                    state_d = no_work ? DONE : MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_d = WRITE;
                end else begin
                    tap_d = tap_q + FILTER_SIZE_REG_SIZE'(1);
                end
            end
            WRITE: begin
                if (!psum_full) begin
                    out_d = out_q + PSUM_POINTER_SIZE'(1);
                    if (window_fits) begin
                        base_d  = base_q + IFMAP_POINTER_SIZE'(s_q);
                        tap_d   = '0;
                        state_d = MAC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode; strobes are masked while chip_en is low.
    always_comb begin
        ifmap_raddr  = base_q + IFMAP_POINTER_SIZE'(tap_q);
        filter_raddr = FILTER_POINTER_SIZE'(tap_q);
        mac_en       = chip_en && (state_q == MAC);
        acc_clr      = (state_q == MAC) && (tap_q == '0);
        psum_wen     = chip_en && (state_q == WRITE) && !psum_full;
        psum_waddr   = out_q;
        busy         = (state_q != IDLE);
        done         = chip_en && (state_q == DONE);
        state_dbg    = state_q;
    end

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Testbench for conv_row_scheduler: an event generator predicts every
// mac/write/done strobe with its relative cycle, and a negedge monitor
// compares what the DUT emits against that expected queue.
module tb_conv_row_scheduler;

    localparam int W = 24;

    logic       clk;
    logic       rst;
    logic       chip_en;
    logic       start;
    logic [2:0] stride;
    logic [1:0] filter_size;
    logic [4:0] row_len;
    logic       psum_full;
    logic [3:0] ifmap_raddr;
    logic [3:0] filter_raddr;
    logic       mac_en;
    logic       acc_clr;
    logic       psum_wen;
    logic [3:0] psum_waddr;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int t0 = 0;

    conv_row_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .chip_en      (chip_en),
        .start        (start),
        .stride       (stride),
        .filter_size  (filter_size),
        .row_len      (row_len),
        .psum_full    (psum_full),
        .ifmap_raddr  (ifmap_raddr),
        .filter_raddr (filter_raddr),
        .mac_en       (mac_en),
        .acc_clr      (acc_clr),
        .psum_wen     (psum_wen),
        .psum_waddr   (psum_waddr),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // Event words: {kind={done,wen,mac}, acc_clr, ifmap, filter, psum, rel}.
    function automatic logic [W-1:0] mac_word(input int first, input int ia, input int fa, input int rel);
        return {3'b001, (first != 0), 4'(ia), 4'(fa), 4'd0, 8'(rel)};
    endfunction

    function automatic logic [W-1:0] wr_word(input int pa, input int rel);
        return {3'b010, 1'b0, 8'd0, 4'(pa), 8'(rel)};
    endfunction

    function automatic logic [W-1:0] done_word(input int rel);
        return {3'b100, 13'd0, 8'(rel)};
    endfunction

    function automatic logic in_win(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Predict the strobe sequence of one pass; events after 'limit' are dropped.
    task automatic build_model(input int l, input int k, input int s,
                               input int st_lo, input int st_hi,
                               input int fz_lo, input int fz_hi,
                               input int limit, output int done_cyc);
        int se;
        int cyc;
        int idx;
        se  = (s == 0) ? 1 : s;
        cyc = 1;
        idx = 0;
        if (k >= 1 && l >= k) begin
            for (int b = 0; b + k <= l; b += se) begin
                for (int t = 0; t < k; t++) begin
                    while (in_win(cyc, fz_lo, fz_hi)) cyc++;
                    if (cyc <= limit) exp_q.push_back(mac_word(t == 0, b + t, t, cyc));
                    cyc++;
                end
                while (in_win(cyc, fz_lo, fz_hi) || in_win(cyc, st_lo, st_hi)) cyc++;
                if (cyc <= limit) exp_q.push_back(wr_word(idx, cyc));
                idx++;
                cyc++;
            end
        end
        while (in_win(cyc, fz_lo, fz_hi)) cyc++;
        if (cyc <= limit) exp_q.push_back(done_word(cyc));
        done_cyc = cyc;
    endtask

    // Monitor: every strobe cycle pops and compares one expected event.
    always @(negedge clk) begin
        logic [2:0]   kind;
        logic [7:0]   rel;
        logic [W-1:0] obs;
        kind = {done, psum_wen, mac_en};
        rel  = 8'(cyc_cnt - t0);
        if (kind != 3'b000) begin
            if (kind == 3'b001)      obs = {kind, acc_clr, ifmap_raddr, filter_raddr, 4'd0, rel};
            else if (kind == 3'b010) obs = {kind, 1'b0, 8'd0, psum_waddr, rel};
            else                     obs = {kind, 13'd0, rel};
            if (exp_q.size() == 0) check("spurious_strobe", 32'(obs), 32'd0);
            else if (kind == 3'b001) check("mac_event", 32'(obs), 32'(exp_q.pop_front()));
            else if (kind == 3'b010) check("write_event", 32'(obs), 32'(exp_q.pop_front()));
            else check("done_event", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    // Driver for one pass. Stall/freeze windows are inclusive relative cycles
    // (lo > hi means none); restart_at pulses start mid-pass; abort_at > 0
    // asserts rst during that cycle and checks the outputs in the next.
    task automatic run_pass(input int l, input int k, input int s,
                            input int st_lo, input int st_hi,
                            input int fz_lo, input int fz_hi,
                            input int restart_at, input int abort_at);
        int done_cyc;
        int end_r;
        int limit;
        @(posedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_state", 32'(state_dbg), 32'd0);
        row_len     = 5'(l);
        filter_size = 2'(k);
        stride      = 3'(s);
        start       = 1'b1;
        psum_full   = 1'b0;
        chip_en     = 1'b1;
        t0          = cyc_cnt;
        limit       = (abort_at > 0) ? abort_at : 1000;
        build_model(l, k, s, st_lo, st_hi, fz_lo, fz_hi, limit, done_cyc);
        end_r = (abort_at > 0) ? abort_at + 1 : done_cyc;
        for (int r = 1; r <= end_r; r++) begin
            @(posedge clk);
            #1;
            start = (r == restart_at);
            if (r == 2) begin
                row_len     = 5'($urandom_range(0, 31));
                stride      = 3'($urandom_range(0, 7));
                filter_size = 2'($urandom_range(0, 3));
            end
            psum_full = in_win(r, st_lo, st_hi);
            chip_en   = !in_win(r, fz_lo, fz_hi);
            rst       = (r == abort_at);
            @(negedge clk);
            if (r == 1) check("busy_first", 32'(busy), 32'd1);
            if (abort_at > 0 && r == abort_at + 1)
                check("abort_outputs",
                      32'({mac_en, acc_clr, psum_wen, done, busy, ifmap_raddr,
                           filter_raddr, psum_waddr, state_dbg}), 32'd0);
        end
        start     = 1'b0;
        chip_en   = 1'b1;
        psum_full = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        chip_en     = 1'b1;
        start       = 1'b0;
        stride      = 3'd0;
        filter_size = 2'd0;
        row_len     = 5'd0;
        psum_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_strobes", 32'({mac_en, acc_clr, psum_wen, done, busy}), 32'd0);
        check("reset_addrs", 32'({ifmap_raddr, filter_raddr, psum_waddr}), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);

        // L=7 K=3 S=2, no stalls: done at 13.
        run_pass(7, 3, 2, 0, -1, 0, -1, 0, 0);
        // L=5 K=3 stride 0 behaves as stride 1: done at 13.
        run_pass(5, 3, 0, 0, -1, 0, -1, 0, 0);
        // L=2 K=3: no outputs, done at 1.
        run_pass(2, 3, 1, 0, -1, 0, -1, 0, 0);
        // K=0: no outputs.
        run_pass(9, 0, 1, 0, -1, 0, -1, 0, 0);
        // psum_full in cycles 4..6: first write moves to 7, done to 16.
        run_pass(7, 3, 2, 4, 6, 0, -1, 0, 0);
        // chip_en low in cycles 2..3, extra start in cycle 8 ignored.
        run_pass(7, 3, 2, 0, -1, 2, 3, 8, 0);
        // rst in cycle 6 aborts the pass, then a full pass runs cleanly.
        run_pass(7, 3, 2, 0, -1, 0, -1, 0, 6);
        run_pass(7, 3, 2, 0, -1, 0, -1, 0, 0);
        // Boundaries: full-length row, widest stride, single-tap filter.
        run_pass(16, 3, 7, 0, -1, 0, -1, 0, 0);
        run_pass(16, 1, 1, 0, -1, 0, -1, 0, 0);
        run_pass(3, 3, 5, 4, 4, 0, -1, 0, 0);

        for (int i = 0; i < 10; i++) begin
            int l, k, s, st_lo, st_len, fz_lo, fz_len;
            l      = $urandom_range(0, 16);
            k      = $urandom_range(0, 3);
            s      = $urandom_range(0, 7);
            st_lo  = $urandom_range(1, 20);
            st_len = $urandom_range(0, 3);
            fz_lo  = $urandom_range(2, 12);
            fz_len = $urandom_range(0, 2);
            run_pass(l, k, s, st_lo, st_lo + st_len - 1, fz_lo, fz_lo + fz_len - 1,
                     $urandom_range(2, 6), 0);
        end

        @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'({busy, state_dbg}), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
